// File: rtl/i2c_seq_matcher.sv
// Passive I2C sniffer: matches a masked address and byte pattern,
// reports match/mismatch and streams every received byte.
module i2c_seq_matcher #(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [6:0]           ADDR        = 7'h50,
  parameter logic [6:0]           ADDR_MASK   = 7'h7F,
  parameter logic                 RW_EXP      = 1'b0,
  parameter int                   PAT_LEN     = 4,
  parameter logic [8*PAT_LEN-1:0] PATTERN     = 32'hA5_3C_00_FF,
  parameter logic [8*PAT_LEN-1:0] PAT_MASK    = 32'hFFFF_FFFF,
  parameter bit                   CHECK_ACK   = 1'b1,
  localparam int                  IW = $clog2(PAT_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sda,
  input  logic          scl,
  input  logic          enable,
  output logic          match,
  output logic          mismatch,
  output logic [7:0]    byte_data,
  output logic          byte_valid,
  output logic [IW-1:0] byte_idx,
  output logic          busy,
  output logic [2:0]    state_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_AACK = 3'd2,
    S_DATA = 3'd3,
    S_DACK = 3'd4,
    S_DONE = 3'd5,
    S_WAIT = 3'd6
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sda_sh, scl_sh;
  logic sda_h, scl_h;
  logic sda_s, scl_s;
  logic scl_rise, start_c, stop_c;

  logic [2:0]    cnt, cnt_n;
  logic [7:0]    sh, sh_n, sh_new;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic [7:0]    bd_n;
  logic          bv_n, m_n, mm_n;
  logic [7:0]    pat_b, pmask_b;
  logic          addr_ok, data_ok, ack_ok;
  logic          in_frame, last_byte;

  // Idle bus is high; seeding the chain with 1s avoids a fake edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_sh <= '1;
      scl_sh <= '1;
      sda_h  <= 1'b1;
      scl_h  <= 1'b1;
    end else begin
      sda_sh <= {sda_sh[SYNC_STAGES-2:0], sda};
      scl_sh <= {scl_sh[SYNC_STAGES-2:0], scl};
      sda_h  <= sda_sh[SYNC_STAGES-1];
      scl_h  <= scl_sh[SYNC_STAGES-1];
    end
  end

  assign sda_s    = sda_sh[SYNC_STAGES-1];
  assign scl_s    = scl_sh[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_h;
  assign start_c  = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_c   = scl_s & scl_h & ~sda_h & sda_s;
  assign sh_new   = {sh[6:0], sda_s};

  always_comb begin
    pat_b   = '0;
    pmask_b = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (idx == IW'(i)) begin
        pat_b   = PATTERN[8*(PAT_LEN-1-i) +: 8];
        pmask_b = PAT_MASK[8*(PAT_LEN-1-i) +: 8];
      end
    end
  end

  assign addr_ok = (((sh_new[7:1] ^ ADDR) & ADDR_MASK) == 7'd0)
                 && (sh_new[0] == RW_EXP);
  assign data_ok = ((sh_new ^ pat_b) & pmask_b) == 8'd0;
  assign ack_ok  = !sda_s || !CHECK_ACK;

  assign in_frame = (state == S_ADDR) || (state == S_AACK)
                 || (state == S_DATA) || (state == S_DACK);

  assign last_byte = (idx == IW'(PAT_LEN));
  assign idx_inc   = last_byte ? idx : idx + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    idx_n   = idx;
    bd_n    = byte_data;
    bv_n    = 1'b0;
    m_n     = 1'b0;
    mm_n    = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else if (start_c) begin
      state_n = S_ADDR;
      cnt_n   = '0;
      idx_n   = '0;
      mm_n    = in_frame;
    end else if (stop_c) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      mm_n    = in_frame;
    end else if (scl_rise) begin
      unique case (state)
        S_ADDR: begin
          sh_n  = sh_new;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            bv_n  = 1'b1;
            bd_n  = sh_new;
            idx_n = '0;
            if (addr_ok) begin
              state_n = S_AACK;
            end else begin
              mm_n    = 1'b1;
              state_n = S_WAIT;
            end
          end
        end
        S_AACK: begin
          if (ack_ok) begin
            state_n = S_DATA;
          end else begin
            mm_n    = 1'b1;
            state_n = S_WAIT;
          end
        end
        S_DATA: begin
          sh_n  = sh_new;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            bv_n  = 1'b1;
            bd_n  = sh_new;
            idx_n = idx_inc;
            if (data_ok) begin
              state_n = S_DACK;
            end else begin
              mm_n    = 1'b1;
              state_n = S_WAIT;
            end
          end
        end
        S_DACK: begin
          if (!ack_ok) begin
            mm_n    = 1'b1;
            state_n = S_WAIT;
          end else if (last_byte) begin
            m_n     = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sh         <= '0;
      idx        <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      idx        <= idx_n;
      byte_data  <= bd_n;
      byte_valid <= bv_n;
      match      <= m_n;
      mismatch   <= mm_n;
    end
  end

  assign byte_idx  = idx;
  assign busy      = (state != S_IDLE);
  assign state_out = state;

endmodule

// File: tb/tb_i2c_seq_matcher.sv
// Bench for i2c_seq_matcher: random I2C frames, bit-level model,
// queue scoreboard for two parameterisations sharing one bus.
module tb_i2c_seq_matcher;

  localparam int          SYNC = 2;
  localparam int          PL   = 4;
  localparam logic [31:0] PAT  = 32'hA5_3C_00_FF;

  logic clk = 1'b0;
  logic reset, sda, scl, enable;

  logic       a_m, a_mm, a_bv, a_busy;
  logic [7:0] a_bd;
  logic [2:0] a_bi, a_st;
  logic       b_m, b_mm, b_bv, b_busy;
  logic [7:0] b_bd;
  logic [2:0] b_bi, b_st;

  always #5 clk = ~clk;

  i2c_seq_matcher #(
    .SYNC_STAGES(SYNC), .ADDR(7'h50), .ADDR_MASK(7'h7F),
    .RW_EXP(1'b0), .PAT_LEN(PL), .PATTERN(PAT),
    .PAT_MASK(32'hFFFF_FFFF), .CHECK_ACK(1'b1)
  ) u_a (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl),
    .enable(enable), .match(a_m), .mismatch(a_mm),
    .byte_data(a_bd), .byte_valid(a_bv), .byte_idx(a_bi),
    .busy(a_busy), .state_out(a_st)
  );

  i2c_seq_matcher #(
    .SYNC_STAGES(SYNC), .ADDR(7'h50), .ADDR_MASK(7'h7E),
    .RW_EXP(1'b0), .PAT_LEN(PL), .PATTERN(PAT),
    .PAT_MASK(32'hFFFF_FFFF), .CHECK_ACK(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl),
    .enable(enable), .match(b_m), .mismatch(b_mm),
    .byte_data(b_bd), .byte_valid(b_bv), .byte_idx(b_bi),
    .busy(b_busy), .state_out(b_st)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         idx;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  errors = 0;

  bit         bq[$];
  int         ending;
  bit         in_sr;
  logic [7:0] fb[0:7];
  bit         fa[0:7];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int j);
    logic [31:0] p;
    p = PAT >> (8 * (PL - 1 - j));
    return p[7:0];
  endfunction

  task automatic push(input int inst, input int kind,
                      input logic [7:0] d, input int idx);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.idx  = idx;
    if (inst == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Reference: walk the sampled bit stream in 8+1 bit groups.
  task automatic model(input int inst);
    logic [6:0] am;
    bit         ca, ok, alive;
    int         pos, k;
    logic [7:0] by;
    am    = (inst == 0) ? 7'h7F : 7'h7E;
    ca    = (inst == 0);
    pos   = 0;
    k     = 0;
    alive = 1;
    while (alive && (bq.size() - pos >= 8)) begin
      by = 8'h00;
      for (int i = 0; i < 8; i++) by = {by[6:0], bq[pos+i]};
      pos += 8;
      push(inst, 0, by, k);
      if (k == 0)
        ok = (((by[7:1] ^ 7'h50) & am) == 7'd0) && !by[0];
      else
        ok = (by == pat_byte(k - 1));
      if (!ok) begin
        push(inst, 2, 8'h00, 0);
        alive = 0;
        break;
      end
      if (pos >= bq.size()) break;
      if (bq[pos] && ca) begin
        push(inst, 2, 8'h00, 0);
        alive = 0;
        break;
      end
      pos++;
      if (k == PL) begin
        push(inst, 1, 8'h00, 0);
        alive = 0;
        break;
      end
      k++;
    end
    if (alive && ending <= 1) push(inst, 2, 8'h00, 0);
  endtask

  task automatic expect_ev(input int inst, input int kind,
                           input logic [7:0] d, input logic [2:0] bi);
    ev_t   e;
    string p;
    p = (inst == 0) ? "a" : "b";
    if ((inst == 0 && qa.size() == 0) ||
        (inst == 1 && qb.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got kind %0d expected none",
               p, kind);
    end else begin
      e = (inst == 0) ? qa.pop_front() : qb.pop_front();
      check({p, "_kind"}, 32'(kind), 32'(e.kind));
      if (kind == 0 && e.kind == 0) begin
        check({p, "_byte"}, 32'(d), 32'(e.data));
        check({p, "_idx"}, 32'(bi), 32'(e.idx));
      end
    end
  endtask

  task automatic mon(input int inst, input logic bv,
                     input logic [7:0] bd, input logic [2:0] bi,
                     input logic m, input logic mm);
    if (m && mm) begin
      checks++;
      errors++;
      $display("FAIL both_pulses: got match=1 mismatch=1 expected one");
    end
    if (bv) expect_ev(inst, 0, bd, bi);
    if (m)  expect_ev(inst, 1, 8'h00, 3'd0);
    if (mm) expect_ev(inst, 2, 8'h00, 3'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, a_bv, a_bd, a_bi, a_m, a_mm);
      mon(1, b_bv, b_bd, b_bi, b_m, b_mm);
    end
  end

  task automatic chk_zero(input string p, input logic m,
                          input logic mm, input logic bv,
                          input logic [7:0] bd, input logic [2:0] bi,
                          input logic bs, input logic [2:0] st);
    check({p, "_rst_match"}, 32'(m), 0);
    check({p, "_rst_mismatch"}, 32'(mm), 0);
    check({p, "_rst_bvalid"}, 32'(bv), 0);
    check({p, "_rst_bdata"}, 32'(bd), 0);
    check({p, "_rst_bidx"}, 32'(bi), 0);
    check({p, "_rst_busy"}, 32'(bs), 0);
    check({p, "_rst_state"}, 32'(st), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    if ($urandom_range(0, 3) == 0) begin
      sda = ~sda;
      tick(1);
      sda = ~sda;
      tick(1);
    end
    sda = b;
    tick(4);
    scl = 1'b1;
    tick(8);
    scl = 1'b0;
    tick(4);
  endtask

  task automatic send_start;
    sda = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(8);
    sda = 1'b0;
    tick(8);
    scl = 1'b0;
    tick(4);
  endtask

  // end_kind: 0 STOP, 1 repeated START, 2 enable drop, 3 reset.
  task automatic run_frame(input int nb, input int partial,
                           input int end_kind);
    int nbits;
    bq.delete();
    for (int b = 0; b < nb; b++) begin
      for (int i = 7; i >= 0; i--) bq.push_back(fb[b][i]);
      bq.push_back(fa[b]);
    end
    for (int i = 0; i < partial; i++)
      bq.push_back(1'($urandom_range(0, 1)));
    nbits = bq.size();
    // STOP and Sr each begin with one scl rise the sniffer samples.
    if (end_kind == 0) bq.push_back(1'b0);
    if (end_kind == 1) bq.push_back(1'b1);
    ending = end_kind;
    model(0);
    model(1);
    if (!in_sr) send_start;
    for (int i = 0; i < nbits; i++) send_bit(bq[i]);
    in_sr = 0;
    case (end_kind)
      0: begin
        sda = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(8);
        sda = 1'b1;
        tick(SYNC + 2);
        check("a_busy_after_stop", 32'(a_busy), 0);
        check("b_busy_after_stop", 32'(b_busy), 0);
        tick(6);
      end
      1: begin
        send_start;
        in_sr = 1;
      end
      2: begin
        enable = 1'b0;
        tick(2);
        check("a_busy_disabled", 32'(a_busy), 0);
        check("b_busy_disabled", 32'(b_busy), 0);
        enable = 1'b1;
        tick(4);
        sda = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(8);
        sda = 1'b1;
        tick(8);
      end
      default: begin
        tick(4);
        reset = 1'b1;
        #1;
        chk_zero("a", a_m, a_mm, a_bv, a_bd, a_bi, a_busy, a_st);
        chk_zero("b", b_m, b_mm, b_bv, b_bd, b_bi, b_busy, b_st);
        tick(3);
        reset = 1'b0;
        tick(4);
        sda = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(8);
        sda = 1'b1;
        tick(8);
      end
    endcase
  endtask

  task automatic load(input logic [7:0] a);
    fb[0] = a;
    fa[0] = 1'b0;
    for (int b = 1; b < 8; b++) begin
      fb[b] = (b <= PL) ? pat_byte(b - 1) : 8'($urandom);
      fa[b] = 1'b0;
    end
  endtask

  initial begin
    int r, nb, pa, ek;
    logic [6:0] ad;
    reset  = 1'b1;
    sda    = 1'b1;
    scl    = 1'b1;
    enable = 1'b1;
    in_sr  = 0;
    tick(3);
    chk_zero("a", a_m, a_mm, a_bv, a_bd, a_bi, a_busy, a_st);
    chk_zero("b", b_m, b_mm, b_bv, b_bd, b_bi, b_busy, b_st);
    reset = 1'b0;
    tick(6);

    load(8'hA0);
    run_frame(5, 0, 0);
    load(8'hA2);
    run_frame(5, 0, 0);
    load(8'hA0);
    fa[2] = 1'b1;
    run_frame(5, 0, 0);
    load(8'hA0);
    run_frame(2, 0, 1);
    load(8'hA0);
    run_frame(5, 0, 0);
    load(8'hA0);
    run_frame(3, 0, 0);
    load(8'hA0);
    run_frame(1, 3, 3);
    load(8'hA0);
    run_frame(3, 2, 2);

    for (int f = 0; f < 30; f++) begin
      r  = $urandom_range(0, 3);
      ad = (r == 0) ? 7'h50 : (r == 1) ? 7'h51 : 7'($urandom);
      load({ad, 1'($urandom_range(0, 7) == 0)});
      for (int b = 1; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) fb[b] = 8'($urandom);
        fa[b] = ($urandom_range(0, 7) == 0);
      end
      nb = $urandom_range(0, 6);
      pa = $urandom_range(0, 7);
      r  = $urandom_range(0, 19);
      ek = (r < 10) ? 0 : (r < 15) ? 1 : (r < 18) ? 2 : 3;
      run_frame(nb, pa, ek);
    end

    load(8'hA0);
    run_frame(5, 0, 0);
    tick(20);
    check("a_queue_left", 32'(qa.size()), 0);
    check("b_queue_left", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
